// File: rtl/washer_timer.sv
// washer_timer
//   Phase timer for the washing-machine controller. The controller pulses R at
//   the start of each phase and then polls the done flag for that phase. One
//   saturating up-counter measures the cycles since the last reset. Each flag
//   is a combinational compare of the counter against a duration that depends
//   on the load size latched at reset.
//
// Ports
//   clk   in   system clock, rising edge
//   R     in   synchronous active-high reset / timer restart; also latches load
//   load  in   [1:0] load size: 00 small, 01 medium, 10/11 large
//   Tf    out  fill time elapsed
//   Tw    out  wash time elapsed
//   Tr    out  rinse time elapsed
//   Td    out  drain time elapsed
//   Ts    out  spin time elapsed
//
// CNT_W must be at least 4 so that the longest duration (11) fits.
module washer_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       R,
  input  logic [1:0] load,
  output logic       Td,
  output logic       Tf,
  output logic       Tr,
  output logic       Ts,
  output logic       Tw
);

  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_load_q;

  logic [CNT_W-1:0] w_d_fill;
  logic [CNT_W-1:0] w_d_wash;
  logic [CNT_W-1:0] w_d_rinse;
  logic [CNT_W-1:0] w_d_drain;
  logic [CNT_W-1:0] w_d_spin;

  // Counter saturates at all-ones rather than wrapping, which keeps every
  // flag asserted until the next reset however long the phase lasts.
  always_ff @(posedge clk) begin
    if (R) begin
      r_count  <= '0;
      r_load_q <= load;
    end else if (r_count != '1) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Duration table indexed by the load size captured at the last reset.
  always_comb begin
    w_d_fill  = CNT_W'(6);
    w_d_wash  = CNT_W'(11);
    w_d_rinse = CNT_W'(8);
    w_d_drain = CNT_W'(5);
    w_d_spin  = CNT_W'(10);
    case (r_load_q)
      2'b00: begin
        w_d_fill  = CNT_W'(2);
        w_d_wash  = CNT_W'(5);
        w_d_rinse = CNT_W'(4);
        w_d_drain = CNT_W'(3);
        w_d_spin  = CNT_W'(6);
      end
      2'b01: begin
        w_d_fill  = CNT_W'(4);
        w_d_wash  = CNT_W'(8);
        w_d_rinse = CNT_W'(6);
        w_d_drain = CNT_W'(4);
        w_d_spin  = CNT_W'(8);
      end
      default: begin
        w_d_fill  = CNT_W'(6);
        w_d_wash  = CNT_W'(11);
        w_d_rinse = CNT_W'(8);
        w_d_drain = CNT_W'(5);
        w_d_spin  = CNT_W'(10);
      end
    endcase
  end

  assign Tf = (r_count >= w_d_fill);
  assign Tw = (r_count >= w_d_wash);
  assign Tr = (r_count >= w_d_rinse);
  assign Td = (r_count >= w_d_drain);
  assign Ts = (r_count >= w_d_spin);

endmodule

// File: tb/tb_washer_timer.sv
// Testbench for washer_timer: directed test-plan sequence followed by random
// reset/load stimulus, checked against an elapsed-cycles reference model.
module tb_washer_timer;

  localparam int unsigned CNT_W = 8;
  localparam int SAT = (1 << CNT_W) - 1;

  logic       clk;
  logic       R;
  logic [1:0] load;
  logic       Td, Tf, Tr, Ts, Tw;

  washer_timer #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .R    (R),
    .load (load),
    .Td   (Td),
    .Tf   (Tf),
    .Tr   (Tr),
    .Ts   (Ts),
    .Tw   (Tw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edges since the last reset (clipped at saturation) and
  // the load size seen on the last reset edge. Flag order: Tf Tw Tr Td Ts.
  int    elapsed;
  int    mload;
  int    n_tests;
  int    n_fail;
  int    dur [4][5] = '{'{2, 5, 4, 3, 6},
                        '{4, 8, 6, 4, 8},
                        '{6, 11, 8, 5, 10},
                        '{6, 11, 8, 5, 10}};
  string fname [5] = '{"Tf", "Tw", "Tr", "Td", "Ts"};

  task automatic check_flags(input string tag);
    logic [4:0] got;
    logic       want;
    got = {Tf, Tw, Tr, Td, Ts};
    for (int i = 0; i < 5; i++) begin
      want = (elapsed >= dur[mload][i]);
      n_tests++;
      assert (got[4-i] === want) else begin
        n_fail++;
        $error("FAIL %s %s: got %b want %b (elapsed %0d load %0d)",
               tag, fname[i], got[4-i], want, elapsed, mload);
      end
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, check.
  task automatic step(input logic r, input logic [1:0] ld, input string tag);
    R    = r;
    load = ld;
    @(posedge clk);
    if (r) begin
      elapsed = 0;
      mload   = int'(ld);
    end else if (elapsed < SAT) begin
      elapsed++;
    end
    #1;
    check_flags(tag);
  endtask

  // Direct check of the first-rise edge for one flag, independent of the model.
  task automatic run_expect_rise(input int flag, input int edge_n, input string tag);
    logic [4:0] got;
    for (int e = 1; e <= edge_n; e++) begin
      step(1'b0, load, tag);
      got = {Tf, Tw, Tr, Td, Ts};
      n_tests++;
      assert (got[4-flag] === (e == edge_n)) else begin
        n_fail++;
        $error("FAIL %s %s edge %0d: got %b want %b",
               tag, fname[flag], e, got[4-flag], (e == edge_n));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] all;
    n_tests = 0;
    n_fail  = 0;
    elapsed = 0;
    mload   = 0;
    R       = 1'b1;
    load    = 2'b00;

    // Held reset, small load.
    for (int i = 0; i < 10; i++) step(1'b1, 2'b00, "hold_reset");

    // Small-load run; Tw expected first high after edge 5.
    run_expect_rise(1, 5, "small_tw");
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00, "small_run");

    // Medium load.
    step(1'b1, 2'b01, "reset_med");
    run_expect_rise(0, 4, "med_tf");
    for (int i = 0; i < 8; i++) step(1'b0, 2'b01, "med_run");

    // Large and load=11 must match.
    step(1'b1, 2'b10, "reset_large");
    run_expect_rise(1, 11, "large_tw");
    step(1'b1, 2'b11, "reset_l11");
    run_expect_rise(3, 5, "l11_td");
    for (int i = 0; i < 8; i++) step(1'b0, 2'b11, "l11_run");

    // Load change while running is ignored.
    step(1'b1, 2'b00, "reset_chg");
    step(1'b0, 2'b00, "chg_run");
    step(1'b0, 2'b00, "chg_run");
    step(1'b0, 2'b10, "chg_run");
    step(1'b0, 2'b10, "chg_run");
    step(1'b0, 2'b10, "chg_tw5");
    n_tests++;
    assert (Tw === 1'b1) else begin
      n_fail++;
      $error("FAIL chg_tw5: got %b want 1", Tw);
    end

    // Reset mid-count of a large run.
    step(1'b1, 2'b10, "reset_mid");
    for (int i = 0; i < 7; i++) step(1'b0, 2'b10, "mid_run");
    step(1'b1, 2'b10, "mid_reset");
    for (int i = 0; i < 12; i++) step(1'b0, 2'b10, "mid_restart");

    // Saturation: 300 cycles without reset, all flags stay high.
    step(1'b1, 2'b10, "reset_sat");
    for (int i = 0; i < 300; i++) step(1'b0, 2'($urandom_range(0, 3)), "sat_run");
    all = {Tf, Tw, Tr, Td, Ts};
    n_tests++;
    assert (all === 5'b11111) else begin
      n_fail++;
      $error("FAIL sat_all: got %b want 11111", all);
    end

    // Random resets and load changes.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
